// File: rtl/operand_fetch_pkg.sv
// Shared field positions, opcode constants and the destination-write predicate
// for the operand-fetch stage.
package operand_fetch_pkg;

    localparam int unsigned OPC_MSB = 6;
    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RS1_MSB = 19;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_MSB = 24;
    localparam int unsigned RS2_LSB = 20;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Unknown opcodes are treated as writing rd so the scoreboard stays conservative.
    function automatic logic writes_rd(input logic [6:0] opcode);
        logic w_res;
        case (opcode)
            OPC_STORE, OPC_BRANCH: w_res = 1'b0;
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: w_res = 1'b1;
            default: w_res = 1'b1;
        endcase
        return w_res;
    endfunction

endpackage

// File: rtl/opf_scoreboard.sv
// Pending-write scoreboard: one bit per register, x0 never pending.
// busy outputs already discount a writeback landing in the same cycle.
module opf_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          busy1,
    output logic          busy2
);

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_d;

    // Set is applied after clear: the issuing instruction is younger than the writeback.
    always_comb begin
        w_pending_d = r_pending;
        if (clr_en) begin
            w_pending_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            w_pending_d[set_addr] = 1'b1;
        end
        w_pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_d;
        end
    end

    assign busy1 = (rs1 != '0) && r_pending[rs1] && !(clr_en && (clr_addr == rs1));
    assign busy2 = (rs2 != '0) && r_pending[rs2] && !(clr_en && (clr_addr == rs2));

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register-file read, writeback bypass, RAW stall via
// scoreboard, and a single-entry output buffer toward execute.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    output logic [AW-1:0]   rf_r1_addr_o,
    output logic [AW-1:0]   rf_r2_addr_o,
    input  logic [XLEN-1:0] rf_r1_data_i,
    input  logic [XLEN-1:0] rf_r2_data_i,
    input  logic            wb_en_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            rf_we_o,
    output logic [AW-1:0]   rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     out_instr_o,
    output logic [XLEN-1:0] out_rs1_o,
    output logic [XLEN-1:0] out_rs2_o,
    output logic [AW-1:0]   out_rd_o
);

    logic [AW-1:0]   w_rs1;
    logic [AW-1:0]   w_rs2;
    logic [AW-1:0]   w_rd;
    logic [6:0]      w_opcode;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic            w_busy1;
    logic            w_busy2;
    logic            w_hazard;
    logic            w_fire;
    logic            w_set_en;

    logic            r_valid;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [AW-1:0]   r_rd;

    assign w_rs1    = instr_i[RS1_MSB:RS1_LSB];
    assign w_rs2    = instr_i[RS2_MSB:RS2_LSB];
    assign w_rd     = instr_i[RD_MSB:RD_LSB];
    assign w_opcode = instr_i[OPC_MSB:OPC_LSB];

    assign rf_r1_addr_o = w_rs1;
    assign rf_r2_addr_o = w_rs2;
    assign rf_we_o      = wb_en_i;
    assign rf_waddr_o   = wb_addr_i;
    assign rf_wdata_o   = wb_data_i;

    always_comb begin
        if (w_rs1 == '0) begin
            w_op1 = '0;
        end else if (wb_en_i && (wb_addr_i == w_rs1)) begin
            w_op1 = wb_data_i;
        end else begin
            w_op1 = rf_r1_data_i;
        end
        if (w_rs2 == '0) begin
            w_op2 = '0;
        end else if (wb_en_i && (wb_addr_i == w_rs2)) begin
            w_op2 = wb_data_i;
        end else begin
            w_op2 = rf_r2_data_i;
        end
    end

    assign w_hazard   = w_busy1 || w_busy2;
    assign in_ready_o = !w_hazard && (!r_valid || out_ready_i);
    assign w_fire     = in_valid_i && in_ready_o;
    assign w_set_en   = w_fire && writes_rd(w_opcode) && (w_rd != '0);

    opf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .set_en   (w_set_en),
        .set_addr (w_rd),
        .clr_en   (wb_en_i),
        .clr_addr (wb_addr_i),
        .rs1      (w_rs1),
        .rs2      (w_rs2),
        .busy1    (w_busy1),
        .busy2    (w_busy2)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_instr <= instr_i;
            r_rs1   <= w_op1;
            r_rs2   <= w_op2;
            r_rd    <= w_rd;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_valid;
    assign out_instr_o = r_instr;
    assign out_rs1_o   = r_rs1;
    assign out_rs2_o   = r_rs2;
    assign out_rd_o    = r_rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file whose x0
// returns garbage, so the stage's own x0 rule is exercised.
module tb_operand_fetch;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [4:0]  rf_r1_addr_o;
    logic [4:0]  rf_r2_addr_o;
    logic [31:0] rf_r1_data_i;
    logic [31:0] rf_r2_data_i;
    logic        wb_en_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_rs1_o;
    logic [31:0] out_rs2_o;
    logic [4:0]  out_rd_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    operand_fetch dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .instr_i      (instr_i),
        .rf_r1_addr_o (rf_r1_addr_o),
        .rf_r2_addr_o (rf_r2_addr_o),
        .rf_r1_data_i (rf_r1_data_i),
        .rf_r2_data_i (rf_r2_data_i),
        .wb_en_i      (wb_en_i),
        .wb_addr_i    (wb_addr_i),
        .wb_data_i    (wb_data_i),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_instr_o  (out_instr_o),
        .out_rs1_o    (out_rs1_o),
        .out_rs2_o    (out_rs2_o),
        .out_rd_o     (out_rd_o)
    );

    // Register-file model: unwritten regs read 0x1000_0000+index, x0 reads garbage.
    logic [31:0] wval [32];
    logic [31:0] wvld;

    always @(posedge clk_i) begin
        if (rf_we_o && (rf_waddr_o != 5'd0)) begin
            wval[rf_waddr_o] <= rf_wdata_o;
            wvld[rf_waddr_o] <= 1'b1;
        end
    end

    initial wvld = '0;

    always_comb begin
        if (rf_r1_addr_o == 5'd0)  rf_r1_data_i = 32'hDEAD_BEEF;
        else if (wvld[rf_r1_addr_o]) rf_r1_data_i = wval[rf_r1_addr_o];
        else rf_r1_data_i = 32'h1000_0000 + 32'(rf_r1_addr_o);
        if (rf_r2_addr_o == 5'd0)  rf_r2_data_i = 32'hDEAD_BEEF;
        else if (wvld[rf_r2_addr_o]) rf_r2_data_i = wval[rf_r2_addr_o];
        else rf_r2_data_i = 32'h1000_0000 + 32'(rf_r2_addr_o);
    end

    typedef struct {
        logic [31:0] instr;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] exp_rs1;
        logic [31:0] exp_rs2;
        logic [4:0]  exp_rd;
        logic [31:0] exp_pend;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        instr_i     = '0;
        wb_en_i     = 1'b0;
        wb_addr_i   = '0;
        wb_data_i   = '0;
        out_ready_i = 1'b1;

        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_out_instr", out_instr_o, 32'd0);
        chk("rst_out_rs1", out_rs1_o, 32'd0);
        chk("rst_out_rs2", out_rs2_o, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd_o}, 32'd0);
        chk("rst_pending", dut.u_scoreboard.r_pending, 32'd0);
        rst_ni = 1'b1;
        tick();

        // Writeback x5=7 passes straight through to the register file.
        wb_en_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'd7;
        settle();
        chk("pt_we", {31'd0, rf_we_o}, 32'd1);
        chk("pt_waddr", {27'd0, rf_waddr_o}, 32'd5);
        chk("pt_wdata", rf_wdata_o, 32'd7);
        tick();

        // add x1,x5,x0
        wb_en_i = 1'b0; in_valid_i = 1'b1; instr_i = 32'h000280B3;
        settle();
        chk("a1_ready", {31'd0, in_ready_o}, 32'd1);
        chk("a1_r1addr", {27'd0, rf_r1_addr_o}, 32'd5);
        tick();
        in_valid_i = 1'b0;
        settle();
        chk("a1_valid", {31'd0, out_valid_o}, 32'd1);
        chk("a1_rs1", out_rs1_o, 32'd7);
        chk("a1_rs2", out_rs2_o, 32'd0);
        chk("a1_rd", {27'd0, out_rd_o}, 32'd1);
        chk("a1_pend", dut.u_scoreboard.r_pending, 32'h0000_0002);

        // add x2,x1,x0 stalls on x1 until its writeback.
        in_valid_i = 1'b1; instr_i = 32'h00008133;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("raw_stall%0d", i), {31'd0, in_ready_o}, 32'd0);
            tick();
        end
        wb_en_i = 1'b1; wb_addr_i = 5'd1; wb_data_i = 32'd9;
        settle();
        chk("raw_release", {31'd0, in_ready_o}, 32'd1);
        tick();
        wb_en_i = 1'b0; in_valid_i = 1'b0;
        settle();
        chk("raw_rs1", out_rs1_o, 32'd9);
        chk("raw_rd", {27'd0, out_rd_o}, 32'd2);
        chk("raw_pend", dut.u_scoreboard.r_pending, 32'h0000_0004);

        // add x3,x0,x0 with a concurrent write to x0.
        in_valid_i = 1'b1; instr_i = 32'h000001B3;
        wb_en_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'd3;
        tick();
        wb_en_i = 1'b0; in_valid_i = 1'b0;
        settle();
        chk("x0_rs1", out_rs1_o, 32'd0);
        chk("x0_rs2", out_rs2_o, 32'd0);
        chk("x0_pend", dut.u_scoreboard.r_pending, 32'h0000_000C);

        // sw x5,0(x1)
        in_valid_i = 1'b1; instr_i = 32'h0050A023;
        tick();
        in_valid_i = 1'b0;
        settle();
        chk("sw_rs1", out_rs1_o, 32'd9);
        chk("sw_rs2", out_rs2_o, 32'd7);
        chk("sw_pend", dut.u_scoreboard.r_pending, 32'h0000_000C);

        // Backpressure: buffer full, downstream not ready.
        out_ready_i = 1'b0; in_valid_i = 1'b1; instr_i = 32'h00528233;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("bp_ready%0d", i), {31'd0, in_ready_o}, 32'd0);
            chk($sformatf("bp_valid%0d", i), {31'd0, out_valid_o}, 32'd1);
            chk($sformatf("bp_instr%0d", i), out_instr_o, 32'h0050A023);
            chk($sformatf("bp_rs1_%0d", i), out_rs1_o, 32'd9);
            tick();
        end
        out_ready_i = 1'b1;
        settle();
        chk("b2b_ready0", {31'd0, in_ready_o}, 32'd1);
        tick();
        instr_i = 32'h00028333;
        settle();
        chk("b2b_instr0", out_instr_o, 32'h00528233);
        chk("b2b_rs1_0", out_rs1_o, 32'd7);
        chk("b2b_rs2_0", out_rs2_o, 32'd7);
        chk("b2b_ready1", {31'd0, in_ready_o}, 32'd1);
        tick();
        in_valid_i = 1'b0;
        settle();
        chk("b2b_instr1", out_instr_o, 32'h00028333);
        chk("b2b_valid1", {31'd0, out_valid_o}, 32'd1);
        chk("b2b_rd1", {27'd0, out_rd_o}, 32'd6);
        chk("b2b_pend", dut.u_scoreboard.r_pending, 32'h0000_005C);

        // Asynchronous reset in mid-cycle, then a late writeback after release.
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("arst_pend", dut.u_scoreboard.r_pending, 32'd0);
        chk("arst_instr", out_instr_o, 32'd0);
        wb_en_i = 1'b1; wb_addr_i = 5'd2; wb_data_i = 32'd5;
        settle();
        chk("arst_pt_we", {31'd0, rf_we_o}, 32'd1);
        chk("arst_pt_wdata", rf_wdata_o, 32'd5);
        tick();
        rst_ni = 1'b1;
        tick();
        wb_en_i = 1'b0;
        settle();
        chk("late_wb_pend", dut.u_scoreboard.r_pending, 32'd0);
        chk("late_wb_valid", {31'd0, out_valid_o}, 32'd0);

        // Back-to-back issue table; register file now holds x1=9, x2=5, x5=7.
        vecs[0] = '{32'h001283B3, 1'b0, 5'd0,  32'h0,    32'd7,    32'd9,      5'd7,  32'h0000_0080};
        vecs[1] = '{32'h0050A223, 1'b0, 5'd0,  32'h0,    32'd9,    32'd7,      5'd4,  32'h0000_0080};
        vecs[2] = '{32'h00508263, 1'b0, 5'd0,  32'h0,    32'd9,    32'd7,      5'd4,  32'h0000_0080};
        vecs[3] = '{32'h00318433, 1'b1, 5'd3,  32'h55,   32'h55,   32'h55,     5'd8,  32'h0000_0180};
        vecs[4] = '{32'h000003B7, 1'b1, 5'd7,  32'h77,   32'd0,    32'd0,      5'd7,  32'h0000_0180};
        vecs[5] = '{32'h00018533, 1'b1, 5'd8,  32'h1,    32'h55,   32'd0,      5'd10, 32'h0000_0480};
        vecs[6] = '{32'h0000006F, 1'b0, 5'd0,  32'h0,    32'd0,    32'd0,      5'd0,  32'h0000_0480};
        vecs[7] = '{32'h005005B3, 1'b1, 5'd5,  32'h1234, 32'd0,    32'h1234,   5'd11, 32'h0000_0C80};

        for (int v = 0; v < 8; v++) begin
            in_valid_i = 1'b1;
            instr_i    = vecs[v].instr;
            wb_en_i    = vecs[v].wb_en;
            wb_addr_i  = vecs[v].wb_addr;
            wb_data_i  = vecs[v].wb_data;
            settle();
            chk($sformatf("v%0d_ready", v), {31'd0, in_ready_o}, 32'd1);
            chk($sformatf("v%0d_r2addr", v), {27'd0, rf_r2_addr_o}, {27'd0, vecs[v].instr[24:20]});
            tick();
            in_valid_i = 1'b0;
            wb_en_i    = 1'b0;
            settle();
            chk($sformatf("v%0d_valid", v), {31'd0, out_valid_o}, 32'd1);
            chk($sformatf("v%0d_instr", v), out_instr_o, vecs[v].instr);
            chk($sformatf("v%0d_rs1", v), out_rs1_o, vecs[v].exp_rs1);
            chk($sformatf("v%0d_rs2", v), out_rs2_o, vecs[v].exp_rs2);
            chk($sformatf("v%0d_rd", v), {27'd0, out_rd_o}, {27'd0, vecs[v].exp_rd});
            chk($sformatf("v%0d_pend", v), dut.u_scoreboard.r_pending, vecs[v].exp_pend);
        end

        tick();
        chk("drain_valid", {31'd0, out_valid_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
